// File: rtl/uart_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_frame                                                |
// | Description : Oversampling UART receive deframer with parity/stop checks.  |
// |               Define UART_RX_MAJORITY_EN for 2-of-3 mid-bit voting.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_CNT_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int c_MAJ = 1;
`else
    localparam int c_MAJ = 0;
`endif
    // Decision ticks: with voting the commit lands one tick after mid-bit,
    // so the bit-period count (measured from the previous commit) is unchanged.
    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(OVERSAMPLE / 2 - 1 + c_MAJ);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST   = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST  = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST  = c_BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic                   armed_q, armed_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [c_BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             mode_q, mode_d;
    logic                   par_bit_q, par_bit_d;
    logic                   fflag_q, fflag_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   dv_q, dv_d;
    logic                   w_bit;
    logic                   w_exp_par;

`ifdef UART_RX_MAJORITY_EN
    // Last two tick samples; at a commit tick they are the two earlier votes.
    logic [1:0] vote_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vote_q <= 2'b00;
        end else if (baud_tick) begin
            vote_q <= {vote_q[0], rx_s_q};
        end
    end

    assign w_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
    assign w_bit = rx_s_q;
`endif

    assign w_exp_par = mode_q[0] ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        mode_d     = mode_q;
        par_bit_d  = par_bit_q;
        fflag_d    = fflag_q;
        data_out_d = data_out_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        dv_d       = 1'b0;

        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q && !rx_s_q) begin
                        state_d = S_START;
                        armed_d = 1'b0;
                        cnt_d   = '0;
                        mode_d  = parity_type;
                        fflag_d = 1'b0;
                    end else if (rx_s_q) begin
                        armed_d = 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == c_START_LAST) begin
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = w_bit ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + c_CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {w_bit, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == c_DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (mode_q != 2'b00) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + c_BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + c_CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_d     = '0;
                        par_bit_d = w_bit;
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        cnt_d = cnt_q + c_CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_d = '0;
                        if (!w_bit) begin
                            fflag_d = 1'b1;
                        end
                        if (bit_cnt_q == c_STOP_LAST) begin
                            bit_cnt_d  = '0;
                            data_out_d = shift_q;
                            ferr_d     = fflag_q | ~w_bit;
                            perr_d     = (mode_q != 2'b00) && (par_bit_q != w_exp_par);
                            dv_d       = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + c_BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + c_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    armed_d = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            mode_q     <= 2'b00;
            par_bit_q  <= 1'b0;
            fflag_q    <= 1'b0;
            data_out_q <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            par_bit_q  <= par_bit_d;
            fflag_q    <= fflag_d;
            data_out_q <= data_out_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            dv_q       <= dv_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_frame                                             |
// | Description : Randomised frame-level bench for uart_rx_frame.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_frame;

    localparam int c_DB = 8;
    localparam int c_OS = 16;
    localparam int c_SB = 2;

    logic            clk         = 1'b0;
    logic            rst_n       = 1'b0;
    logic            baud_tick   = 1'b0;
    logic            rx          = 1'b1;
    logic [1:0]      parity_type = 2'b00;
    logic [c_DB-1:0] data_out;
    logic            data_valid;
    logic            parity_err;
    logic            frame_err;
    logic            busy;

    uart_rx_frame #(
        .DATA_BITS (c_DB),
        .OVERSAMPLE(c_OS),
        .STOP_BITS (c_SB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .parity_type(parity_type),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int              n_vec = 0;
    int              n_err = 0;
    logic [c_DB-1:0] q_data[$];
    logic            q_perr[$];
    logic            q_ferr[$];
    logic            dv_prev = 1'b0;
    logic [c_DB-1:0] last_d    = '0;
    logic            last_perr = 1'b0;
    logic            last_ferr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Capture every completed frame; a valid pulse must never be two clocks wide.
    always @(negedge clk) begin
        if (data_valid) begin
            chk("dv_width", {31'd0, dv_prev}, 32'd0);
            q_data.push_back(data_out);
            q_perr.push_back(parity_err);
            q_ferr.push_back(frame_err);
        end
        dv_prev = data_valid;
    end

    // One oversample period: rx settles >= 2 clocks before the tick.
    task automatic send_tick(input logic v);
        rx = v;
        if ($urandom_range(0, 199) == 0) repeat (40) @(negedge clk);
        repeat ($urandom_range(2, 4)) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    task automatic send_bit(input logic v);
        repeat (c_OS) send_tick(v);
    endtask

    task automatic send_frame(input logic [c_DB-1:0] d, input logic [1:0] mode,
                              input logic par, input logic [1:0] stops, input int glitch);
        parity_type = mode;
        repeat ($urandom_range(2, 6)) send_tick(1'b1);
        send_bit(1'b0);
        parity_type = 2'($urandom);
        for (int i = 0; i < c_DB; i++) begin
            if (i == glitch) begin
                for (int t = 0; t < c_OS; t++) send_tick((t == c_OS / 2) ? ~d[i] : d[i]);
            end else begin
                send_bit(d[i]);
            end
        end
        if (mode != 2'b00) send_bit(par);
        for (int s = 0; s < c_SB; s++) send_bit(stops[s]);
    endtask

    function automatic logic model_perr(input logic [c_DB-1:0] d, input logic [1:0] mode,
                                        input logic par);
        if (mode == 2'b00) return 1'b0;
        return par != (mode[0] ? ~^d : ^d);
    endfunction

    task automatic expect_frame(input logic [c_DB-1:0] d, input logic perr, input logic ferr);
        for (int k = 0; k < 400 && q_data.size() == 0; k++) @(negedge clk);
        chk("dv_count", q_data.size(), 32'd1);
        if (q_data.size() > 0) begin
            chk("data_out", q_data.pop_front(), d);
            chk("parity_err", q_perr.pop_front(), perr);
            chk("frame_err", q_ferr.pop_front(), ferr);
        end
        chk("busy_after", busy, 32'd0);
        q_data.delete();
        q_perr.delete();
        q_ferr.delete();
        last_d    = d;
        last_perr = perr;
        last_ferr = ferr;
    endtask

    task automatic check_outputs(input string tag, input logic [c_DB-1:0] d,
                                 input logic perr, input logic ferr);
        chk({tag, "_data"}, data_out, d);
        chk({tag, "_perr"}, parity_err, perr);
        chk({tag, "_ferr"}, frame_err, ferr);
        chk({tag, "_dv"}, data_valid, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [c_DB-1:0] d;
        logic [1:0]      mode;
        logic            par;
        logic [1:0]      stops;

        repeat (3) @(negedge clk);
        check_outputs("reset", '0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Even parity, correct parity bit.
        send_frame(8'hA5, 2'b10, 1'b0, 2'b11, -1);
        expect_frame(8'hA5, 1'b0, 1'b0);

        // Odd parity mismatch, then a good odd frame clears the flag.
        send_frame(8'h0F, 2'b01, 1'b0, 2'b11, -1);
        expect_frame(8'h0F, 1'b1, 1'b0);
        send_frame(8'h01, 2'b01, 1'b0, 2'b11, -1);
        expect_frame(8'h01, 1'b0, 1'b0);

        // Second stop bit low, then a 20-bit break must not retrigger.
        send_frame(8'h3C, 2'b00, 1'b0, 2'b01, -1);
        expect_frame(8'h3C, 1'b0, 1'b1);
        repeat (20 * c_OS) send_tick(1'b0);
        chk("break_dv", q_data.size(), 32'd0);
        check_outputs("break", 8'h3C, 1'b0, 1'b1);
        send_frame(8'hC3, 2'b11, 1'b1, 2'b11, -1);
        expect_frame(8'hC3, model_perr(8'hC3, 2'b11, 1'b1), 1'b0);

        // False start: short low pulse.
        repeat (4) send_tick(1'b1);
        repeat (c_OS / 4) send_tick(1'b0);
        repeat (c_OS + 4) send_tick(1'b1);
        chk("fstart_dv", q_data.size(), 32'd0);
        check_outputs("fstart", last_d, last_perr, last_ferr);

        // Reset in the middle of the data field.
        parity_type = 2'b00;
        repeat (4) send_tick(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (5) send_tick(1'b1);
        chk("busy_mid", busy, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs("midrst", '0, 1'b0, 1'b0);
        q_data.delete();
        q_perr.delete();
        q_ferr.delete();
        send_frame(8'h55, 2'b10, 1'b0, 2'b11, -1);
        expect_frame(8'h55, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h00, 2'b10, 1'b0, 2'b11, 2);
        expect_frame(8'h00, 1'b0, 1'b0);
`endif

        // Randomised frames against the frame-level model.
        for (int n = 0; n < 24; n++) begin
            d     = c_DB'($urandom);
            mode  = 2'($urandom);
            par   = (mode[0] ? ~^d : ^d) ^ ($urandom_range(0, 3) == 0);
            stops = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            send_frame(d, mode, par, stops, -1);
            expect_frame(d, model_perr(d, mode, par), ~(stops[0] & stops[1]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised UART receive deframer with built-in parity checking; it succeeds the combinational parity generator.
- Oversamples a serial `rx` line using an external baud tick and assembles DATA_BITS-wide words, LSB first.
- Checks the selectable parity mode and the stop bits, and raises per-frame parity and framing error flags.
- Sits between the pad synchroniser domain and the receive FIFO/host interface of the UART.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- OVERSAMPLE, 16: baud_tick pulses per bit period; must be even and ≥4.
- STOP_BITS, 1: number of stop bits checked; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- baud_tick  input  1  single-cycle enable pulse at OVERSAMPLE× baud rate.
- rx  input  1  asynchronous serial line; idle high.
- parity_type  input  2  parity mode:
  - 2'b00 none.
  - 2'bx1 odd: parity bit = ~^data.
  - 2'b10 even: parity bit = ^data.
- data_out  output  DATA_BITS  last received word.
- data_valid  output  1  one-clk pulse when a frame completes.
- parity_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  any stop bit sampled low on the last frame.
- busy  output  1  high while not in IDLE.

Behaviour:
- **Reset:** rst_n low at a clk edge forces the following, regardless of state, including mid-frame:
  - state = IDLE and armed = 0.
  - data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Synchroniser flops = 1, all counters = 0.
- **Synchronisation:** rx passes through a 2-flop synchroniser to produce rx_s. All decisions use rx_s.
- **Timing base:**
  - A tick counter advances only on baud_tick.
  - Every "sample" below happens on a baud_tick cycle.
- **Arming:** armed is set when rx_s = 1 on a tick in IDLE. A line held low (break) therefore never retriggers.
- **State machine:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: when armed and rx_s = 0 on a tick:
    - latch parity_type into an internal register; a change mid-frame has no effect on that frame;
    - clear armed, clear the tick count, go to START.
  - START: after OVERSAMPLE/2 ticks, sample at mid-start.
    - Sample 1: false start; return to IDLE with no outputs changed.
    - Sample 0: clear the tick count, go to DATA.
  - DATA: sample every OVERSAMPLE ticks into a shift register, LSB first.
    - After DATA_BITS samples, go to PARITY if the latched mode ≠ 00, else STOP.
  - PARITY: one sample after OVERSAMPLE ticks; store the received bit.
  - STOP: STOP_BITS samples, each OVERSAMPLE ticks apart. Any 0 sample sets an internal frame flag.
- **Frame completion:** on the tick of the final stop sample:
  - update data_out and the error flags;
  - pulse data_valid for exactly one clk on the following edge;
  - return to IDLE.
- **Latency:** data_valid rises 1 clk after the baud_tick carrying the last stop sample.
- **Error flags:**
  - parity_err = (mode ≠ 00) && (received parity ≠ expected parity for the latched mode).
  - frame_err = internal frame flag.
  - Both hold until the next completed frame overwrites them, or until reset. A false start never alters them.
- **Held outputs:** data_out holds between frames. It is not cleared by a new start.
- **busy:** asserted in every state except IDLE.
- **Back-to-back frames:** a new frame may begin on the tick immediately after returning to IDLE, provided rx_s is high on that tick to re-arm. A start edge is then detected on a subsequent tick.
- **baud_tick absent:** the state machine freezes; no timeouts.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
  - Defined: each mid-bit decision (start check, data, parity, stop) uses a 2-of-3 majority of rx_s over ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit. The decision is committed on the third sample tick, and latency grows by 1 tick per frame end.
  - Undefined: a single sample at tick OVERSAMPLE/2. No majority logic is synthesised.

Test Plan:
- Even parity: parity_type=2'b10, send 0xA5 with parity bit 0 and 1 stop bit → data_valid pulse once, data_out=0xA5, parity_err=0, frame_err=0.
- Odd parity mismatch: parity_type=2'b01, send 0x0F with parity bit 0 → data_out=0x0F, parity_err=1. A following good frame 0x01 with parity bit 0 → parity_err=0.
- Framing error with STOP_BITS=2: send 0x3C with parity_type=2'b00 and the second stop bit low → frame_err=1, data_out=0x3C. Then hold rx low 20 bit times → no further data_valid until rx returns high and a new start arrives.
- False start: rx low for OVERSAMPLE/4 ticks, then high → busy returns low, no data_valid, prior outputs unchanged.
- Mid-frame reset: assert rst_n=0 during DATA after 3 bits → next clk all outputs 0 and state IDLE. Then a full frame 0x55 → received correctly.
- Majority, with UART_RX_MAJORITY_EN: inject a 1-tick glitch at mid-bit on bit 2 of 0x00 → data_out=0x00, parity_err=0.
